// File: rtl/ascon_round_sequencer.sv
// Ascon permutation round sequencer: accepts a per-request round count, steps
// UNROLL rounds per cycle and emits per-lane round constants plus framing flags.
module ascon_round_sequencer #(
    parameter int unsigned MAX_ROUNDS = 12,
    parameter int unsigned UNROLL     = 1,
    parameter int unsigned CTR_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    input  logic [CTR_W-1:0]      start_rounds,
    output logic                  start_ready,
    input  logic                  abort,
    output logic                  round_en,
    output logic [CTR_W-1:0]      round_idx,
    output logic [8*UNROLL-1:0]   rc,
    output logic                  first_round,
    output logic                  last_round,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned SUM_W = CTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CTR_W-1:0]  cnt_q;
    logic [CTR_W-1:0]  n_q;
    logic              err_q;

    logic              handshake;
    logic              req_ok;
    logic [SUM_W-1:0]  cnt_sum;
    logic              is_last;

    assign handshake = start_valid && start_ready;

    // Reject zero, oversize, or counts that are not a whole number of cycles
    assign req_ok = (start_rounds != '0)
                 && ({1'b0, start_rounds} <= SUM_W'(MAX_ROUNDS))
                 && ((32'(start_rounds) % 32'(UNROLL)) == 32'd0);

    // One extra bit so the last-round compare cannot wrap
    assign cnt_sum = {1'b0, cnt_q} + SUM_W'(UNROLL);
    assign is_last = (cnt_sum == {1'b0, n_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        if (req_ok) begin
                            n_q     <= start_rounds;
                            cnt_q   <= '0;
                            state_q <= S_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= CTR_W'(cnt_sum);
                        if (is_last) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_q == S_IDLE) && !abort;
    assign round_en    = (state_q == S_RUN);
    assign round_idx   = round_en ? cnt_q : '0;
    assign first_round = round_en && (cnt_q == '0);
    assign last_round  = round_en && is_last;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

    // Shorter runs start part-way into the constant table so they end on the same constant
    for (genvar k = 0; k < UNROLL; k++) begin : g_lane
        logic [SUM_W-1:0] idx;
        assign idx = SUM_W'(MAX_ROUNDS) - {1'b0, n_q} + {1'b0, cnt_q} + SUM_W'(k);
        assign rc[8*k +: 8] = round_en ? {4'hF - idx[3:0], idx[3:0]} : 8'h00;
    end

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed bench for ascon_round_sequencer: one instance with UNROLL=1 and one with UNROLL=2.
module tb_ascon_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        sv1, ab1, sr1, re1, fr1, lr1, dn1, bz1, er1;
    logic [3:0]  sn1, ri1;
    logic [7:0]  rc1;

    logic        sv2, ab2, sr2, re2, fr2, lr2, dn2, bz2, er2;
    logic [3:0]  sn2, ri2;
    logic [15:0] rc2;

    int total = 0;
    int bad   = 0;

    // Round constants for absolute round index 0..15
    logic [7:0] rct [16] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
                             8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
    logic [15:0] rc_u2 [3] = '{16'h8796, 16'h6978, 16'h4B5A};
    logic [3:0]  bad_n2 [3] = '{4'd5, 4'd0, 4'd13};
    logic [3:0]  bad_n1 [2] = '{4'd0, 4'd13};

    ascon_round_sequencer #(.MAX_ROUNDS(12), .UNROLL(1), .CTR_W(4)) u1 (
        .clk(clk), .rst(rst), .start_valid(sv1), .start_rounds(sn1), .start_ready(sr1),
        .abort(ab1), .round_en(re1), .round_idx(ri1), .rc(rc1), .first_round(fr1),
        .last_round(lr1), .done(dn1), .busy(bz1), .err(er1)
    );

    ascon_round_sequencer #(.MAX_ROUNDS(12), .UNROLL(2), .CTR_W(4)) u2 (
        .clk(clk), .rst(rst), .start_valid(sv2), .start_rounds(sn2), .start_ready(sr2),
        .abort(ab2), .round_en(re2), .round_idx(ri2), .rc(rc2), .first_round(fr2),
        .last_round(lr2), .done(dn2), .busy(bz2), .err(er2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        sv1 = 1'b0; ab1 = 1'b0; sn1 = 4'd0;
        sv2 = 1'b0; ab2 = 1'b0; sn2 = 4'd0;
        #2;
        chk("rst_ready",  32'(sr1), 32'd1);
        chk("rst_en",     32'(re1), 32'd0);
        chk("rst_idx",    32'(ri1), 32'd0);
        chk("rst_rc",     32'(rc1), 32'd0);
        chk("rst_first",  32'(fr1), 32'd0);
        chk("rst_last",   32'(lr1), 32'd0);
        chk("rst_done",   32'(dn1), 32'd0);
        chk("rst_busy",   32'(bz1), 32'd0);
        chk("rst_err",    32'(er1), 32'd0);
        chk("rst_rc2",    32'(rc2), 32'd0);
        #10;
        rst = 1'b0;
        step();

        // Full N=12 run, UNROLL=1
        sn1 = 4'd12; sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("n12_en",    32'(re1), 32'd1);
            chk("n12_rc",    32'(rc1), 32'(rct[i]));
            chk("n12_idx",   32'(ri1), 32'(i));
            chk("n12_first", 32'(fr1), 32'(i == 0));
            chk("n12_last",  32'(lr1), 32'(i == 11));
            chk("n12_ready", 32'(sr1), 32'd0);
            step();
        end
        chk("n12_done",  32'(dn1), 32'd1);
        chk("n12_en_off", 32'(re1), 32'd0);
        chk("n12_rc_off", 32'(rc1), 32'd0);
        step();
        chk("n12_done_clr", 32'(dn1), 32'd0);
        chk("n12_ready_back", 32'(sr1), 32'd1);
        chk("n12_idle", 32'(bz1), 32'd0);

        // N=6 then N=8 back to back; second request held through DONE
        sn1 = 4'd6; sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("n6_rc",   32'(rc1), 32'(rct[6 + i]));
            chk("n6_last", 32'(lr1), 32'(i == 5));
            step();
        end
        chk("n6_done", 32'(dn1), 32'd1);
        sn1 = 4'd8; sv1 = 1'b1;
        chk("n6_done_not_ready", 32'(sr1), 32'd0);
        step();
        chk("gap_en",    32'(re1), 32'd0);
        chk("gap_busy",  32'(bz1), 32'd0);
        chk("gap_ready", 32'(sr1), 32'd1);
        step();
        sv1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("n8_rc",  32'(rc1), 32'(rct[4 + i]));
            chk("n8_idx", 32'(ri1), 32'(i));
            step();
        end
        chk("n8_done", 32'(dn1), 32'd1);
        step();

        // UNROLL=2, N=6
        sn2 = 4'd6; sv2 = 1'b1;
        step();
        sv2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("u2_en",    32'(re2), 32'd1);
            chk("u2_rc",    32'(rc2), 32'(rc_u2[i]));
            chk("u2_idx",   32'(ri2), 32'(2 * i));
            chk("u2_first", 32'(fr2), 32'(i == 0));
            chk("u2_last",  32'(lr2), 32'(i == 2));
            step();
        end
        chk("u2_done", 32'(dn2), 32'd1);
        step();
        chk("u2_idle", 32'(bz2), 32'd0);

        // Invalid requests on both instances
        for (int j = 0; j < 3; j++) begin
            sn2 = bad_n2[j]; sv2 = 1'b1;
            #1;
            chk("inv2_ready", 32'(sr2), 32'd1);
            step();
            sv2 = 1'b0;
            chk("inv2_err",  32'(er2), 32'd1);
            chk("inv2_busy", 32'(bz2), 32'd0);
            chk("inv2_en",   32'(re2), 32'd0);
            step();
            chk("inv2_err_clr", 32'(er2), 32'd0);
            chk("inv2_en2",     32'(re2), 32'd0);
        end
        for (int j = 0; j < 2; j++) begin
            sn1 = bad_n1[j]; sv1 = 1'b1;
            step();
            sv1 = 1'b0;
            chk("inv1_err",  32'(er1), 32'd1);
            chk("inv1_busy", 32'(bz1), 32'd0);
            step();
            chk("inv1_err_clr", 32'(er1), 32'd0);
            chk("inv1_en",      32'(re1), 32'd0);
        end

        // Abort in the 5th round_en cycle
        sn1 = 4'd12; sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ab_pre_en", 32'(re1), 32'd1);
            step();
        end
        ab1 = 1'b1;
        #1;
        chk("ab_en",    32'(re1), 32'd1);
        chk("ab_rc",    32'(rc1), 32'(rct[4]));
        chk("ab_idx",   32'(ri1), 32'd4);
        chk("ab_ready", 32'(sr1), 32'd0);
        step();
        chk("ab_en_off", 32'(re1), 32'd0);
        chk("ab_busy",   32'(bz1), 32'd0);
        chk("ab_done",   32'(dn1), 32'd0);
        chk("ab_rc_off", 32'(rc1), 32'd0);
        chk("ab_idle_ready", 32'(sr1), 32'd0);
        ab1 = 1'b0;
        #1;
        chk("ab_ready_back", 32'(sr1), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ab_no_done", 32'(dn1), 32'd0);
        end
        sn1 = 4'd6; sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        chk("ab_new_rc",    32'(rc1), 32'h96);
        chk("ab_new_first", 32'(fr1), 32'd1);
        for (int i = 0; i < 6; i++) step();
        chk("ab_new_done", 32'(dn1), 32'd1);
        step();

        // Asynchronous reset mid-run
        sn1 = 4'd8; sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        step();
        step();
        chk("ar_idx_pre", 32'(ri1), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_en",    32'(re1), 32'd0);
        chk("ar_busy",  32'(bz1), 32'd0);
        chk("ar_rc",    32'(rc1), 32'd0);
        chk("ar_idx",   32'(ri1), 32'd0);
        chk("ar_ready", 32'(sr1), 32'd1);
        chk("ar_done",  32'(dn1), 32'd0);
        chk("ar_first", 32'(fr1), 32'd0);
        #1;
        rst = 1'b0;
        step();
        chk("ar_post_done", 32'(dn1), 32'd0);
        chk("ar_post_busy", 32'(bz1), 32'd0);
        sn1 = 4'd8; sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ar_n8_rc",   32'(rc1), 32'(rct[4 + i]));
            chk("ar_n8_last", 32'(lr1), 32'(i == 7));
            step();
        end
        chk("ar_n8_done", 32'(dn1), 32'd1);
        step();
        chk("ar_n8_ready", 32'(sr1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_round_sequencer.md
Name: ascon_round_sequencer

Overview:
- Parametrised round sequencer for the Ascon permutation core; supersedes the fixed free-running round counter.
- Accepts a per-request round count (p^a = 12, p^b = 6 or 8) through a valid/ready start handshake and steps through the rounds, UNROLL rounds per cycle.
- Emits per-lane Ascon round constants, first/last flags and a one-cycle done pulse; supports abort and flags invalid requests.
- Sits between the mode controller (init/AD/PT/final FSM) and the permutation datapath.

Parameters:
- MAX_ROUNDS, 12: maximum rounds per permutation; constant indexing base; must be ≤ 16.
- UNROLL, 1: rounds executed per clock; allowed values 1, 2, 3, 4, 6.
- CTR_W, 4: width of the round count and counter; must hold MAX_ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  permutation request.
- start_rounds  in  CTR_W  requested round count N, sampled on handshake.
- start_ready  out  1  sequencer can accept a request.
- abort  in  1  synchronous cancel of the current run.
- round_en  out  1  datapath applies UNROLL rounds this cycle.
- round_idx  out  CTR_W  index of lane-0 round within the current run (0..N-1).
- rc  out  8*UNROLL  round constants; lane k in bits [8k+7:8k].
- first_round  out  1  round_en cycle that contains round 0.
- last_round  out  1  round_en cycle that contains round N-1.
- done  out  1  one-cycle pulse after the last round.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, stored N=0. Outputs: start_ready=1 (when abort=0), round_en=0, round_idx=0, rc=0, first_round=0, last_round=0, done=0, busy=0, err=0.
- States: IDLE, RUN, DONE.
- start_ready = (state==IDLE) && !abort.
- A handshake is start_valid && start_ready.
- Request validity: N is valid iff 1 ≤ N ≤ MAX_ROUNDS and N mod UNROLL == 0.
- Invalid request:
  - err=1 in the next cycle; state stays IDLE; no round_en.
  - The handshake still completes, so the requester does not stall.
- Valid handshake at edge T: store N, counter=0, enter RUN.
  - round_en=1 from cycle T+1 through T+N/UNROLL.
- In RUN, each cycle:
  - round_idx = counter.
  - first_round = (counter==0).
  - last_round = (counter+UNROLL == N).
  - counter += UNROLL at the clock edge.
- Last RUN cycle → DONE; done=1 for exactly one cycle; next cycle → IDLE. Total occupancy is N/UNROLL+1 cycles from acceptance to IDLE.
- Round constants (lane k):
  - idx = MAX_ROUNDS − N + counter + k.
  - rc_k = {4'hF − idx[3:0], idx[3:0]}.
  - rc=0 whenever round_en=0.
- Outputs are registered or decoded from registered state only. There is no combinational path from start_valid to any output except err timing as stated.
- Arithmetic: compute the counter sum at CTR_W+1 bits so the compare cannot wrap. The counter never exceeds N.
- Abort:
  - In RUN or DONE: go to IDLE at the next edge, counter=0, no done pulse. round_en drops the cycle after abort is sampled.
  - In IDLE: no effect except forcing start_ready=0.
  - Abort has priority over start in the same cycle.
- start_valid while busy: ignored (start_ready=0). The request is not queued.
- start_valid in DONE: not accepted. Back-to-back runs have a minimum 1-cycle gap after done.
- Reset mid-run: immediate return to the reset values; no done pulse.

Test Plan:
- N=12, UNROLL=1 → round_en for 12 cycles; rc = F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B; first_round on cycle 1; last_round on cycle 12; done on cycle 13; start_ready=1 on cycle 14.
- N=6 then N=8 back-to-back, UNROLL=1 →
  - Run 1: rc 96..4B over 6 cycles.
  - Second start accepted only when start_ready=1 after done.
  - Run 2: rc B4..4B over 8 cycles.
- UNROLL=2, N=6 → 3 round_en cycles with rc={87,96}, {69,78}, {4B,5A} (upper byte first); round_idx = 0, 2, 4; done on cycle 4.
- UNROLL=2, N=5; also N=0 and N=13 → err pulse one cycle after the handshake; busy stays 0; no round_en.
- N=12, abort asserted in the 5th round_en cycle → round_en=0 from the next cycle; done never pulses; start_ready=1 once abort deasserts; a new N=6 run produces first rc=96.
- rst asserted asynchronously mid-run (not on a clock edge) → all outputs at reset values immediately; no done; a fresh N=8 run completes normally.
